// File: rtl/oflow_similarity_metric_param_if.sv
// Handshake, feature and result bundle of the similarity-metric engine.
// The master drives start, features and the IoU result; the slave returns busy/valid/score/id.
interface oflow_similarity_metric_param_if #(
   parameter int NUM_COLORS    = 2,
   parameter int COLOR_LEN     = 24,
   parameter int WIDTH_LEN     = 8,
   parameter int HEIGHT_LEN    = 8,
   parameter int D_HISTORY_LEN = 3,
   parameter int IOU_LEN       = 22,
   parameter int WEIGHT_LEN    = 8,
   parameter int SCORE_LEN     = 32,
   parameter int ID_LEN        = 8
);
   logic                                  start;
   logic                                  busy;
   logic [WIDTH_LEN-1:0]                  width_cur;
   logic [HEIGHT_LEN-1:0]                 height_cur;
   logic [NUM_COLORS*COLOR_LEN-1:0]       color_cur;
   logic [WIDTH_LEN-1:0]                  width_prev;
   logic [HEIGHT_LEN-1:0]                 height_prev;
   logic [NUM_COLORS*COLOR_LEN-1:0]       color_prev;
   logic [D_HISTORY_LEN-1:0]              d_history_prev;
   logic [ID_LEN-1:0]                     id_prev;
   logic [(NUM_COLORS+4)*WEIGHT_LEN-1:0]  weights;
   logic [IOU_LEN-1:0]                    iou_in;
   logic                                  iou_valid;
   logic                                  valid;
   logic                                  control_for_read_new_line;
   logic [SCORE_LEN-1:0]                  score;
   logic [ID_LEN-1:0]                     id;

   modport master (
      output start, width_cur, height_cur, color_cur, width_prev, height_prev, color_prev,
             d_history_prev, id_prev, weights, iou_in, iou_valid,
      input  busy, valid, control_for_read_new_line, score, id
   );

   modport slave (
      input  start, width_cur, height_cur, color_cur, width_prev, height_prev, color_prev,
             d_history_prev, id_prev, weights, iou_in, iou_valid,
      output busy, valid, control_for_read_new_line, score, id
   );
endinterface

// File: rtl/oflow_similarity_metric_param.sv
// Weighted L1/IoU similarity score, one shared multiplier, one term per cycle.
// Define OFLOW_SIM_SATURATE_EN to clamp the score to all ones instead of wrapping.
//
// state    | meaning
// S_IDLE   | waiting for start, features latched on start
// S_WAIT_IOU | waiting for iou_valid from the IoU unit
// S_MAC    | acc += weight[k] * metric[k], k = 0..NUM_TERMS-1
// S_OUT    | valid pulse, score/id presented
module oflow_similarity_metric_param #(
   parameter int NUM_COLORS    = 2,
   parameter int COLOR_LEN     = 24,
   parameter int WIDTH_LEN     = 8,
   parameter int HEIGHT_LEN    = 8,
   parameter int D_HISTORY_LEN = 3,
   parameter int IOU_LEN       = 22,
   parameter int WEIGHT_LEN    = 8,
   parameter int FRAC_BITS     = 10,
   parameter int SCORE_LEN     = 32,
   parameter int SCORE_FRAC    = 6,
   parameter int ID_LEN        = 8,
   parameter int READ_AHEAD    = 2
) (
   input logic clk,
   input logic reset,
   oflow_similarity_metric_param_if.slave bus
);
   localparam int NUM_TERMS = NUM_COLORS + 4;
   localparam int KW        = $clog2(NUM_TERMS);
   localparam int CH_LEN    = COLOR_LEN / 3;
   localparam int CSUM_W    = CH_LEN + 2;
   localparam int HIST_LEN  = 2 ** D_HISTORY_LEN;
   localparam int WH_W      = (WIDTH_LEN > HEIGHT_LEN) ? WIDTH_LEN : HEIGHT_LEN;
   localparam int WHH_W     = (WH_W > HIST_LEN) ? WH_W : HIST_LEN;
   localparam int INT_W     = (WHH_W > CSUM_W) ? WHH_W : CSUM_W;
   localparam int MET_W     = INT_W + FRAC_BITS;
   localparam int PROD_W    = MET_W + WEIGHT_LEN;
   localparam int SHIFT     = FRAC_BITS - SCORE_FRAC;
   localparam int ACC_W     = SCORE_LEN + SHIFT + 4;
   localparam int RA_K      = (READ_AHEAD >= NUM_TERMS) ? 0 : NUM_TERMS - 1 - READ_AHEAD;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_IOU, S_MAC, S_OUT} state_t;

   state_t                            state_q, state_d;
   logic [KW-1:0]                     k_q, k_d;
   logic [ACC_W-1:0]                  acc_q, acc_d, acc_next;
   logic [SCORE_LEN-1:0]              score_q, score_d, score_next;
   logic [ID_LEN-1:0]                 id_q, id_d;
   logic                              load_feat, load_iou;

   logic [WIDTH_LEN-1:0]              width_cur_q, width_prev_q, w_diff;
   logic [HEIGHT_LEN-1:0]             height_cur_q, height_prev_q, h_diff;
   logic [NUM_COLORS*COLOR_LEN-1:0]   color_cur_q, color_prev_q;
   logic [D_HISTORY_LEN-1:0]          d_history_q;
   logic [ID_LEN-1:0]                 id_prev_q;
   logic [NUM_TERMS*WEIGHT_LEN-1:0]   weights_q;
   logic [FRAC_BITS-1:0]              iou_pad_q;

   logic [HIST_LEN-1:0]               hist;
   logic [CH_LEN-1:0]                 ch_a, ch_b;
   logic [CSUM_W-1:0]                 csum;
   logic [MET_W-1:0]                  metric [NUM_TERMS];
   logic [WEIGHT_LEN-1:0]             wgt;
   logic [PROD_W-1:0]                 prod;

   // All metrics are padded to the common q*.FRAC_BITS format before the MAC.
   always_comb begin
      for (int t = 0; t < NUM_TERMS; t++) metric[t] = '0;
      ch_a   = '0;
      ch_b   = '0;
      csum   = '0;
      w_diff = (width_prev_q > width_cur_q) ? width_prev_q - width_cur_q
                                            : width_cur_q - width_prev_q;
      h_diff = (height_prev_q > height_cur_q) ? height_prev_q - height_cur_q
                                              : height_cur_q - height_prev_q;
      hist   = HIST_LEN'(1) << d_history_q;
      metric[0] = MET_W'(iou_pad_q);
      metric[1] = {INT_W'(w_diff), {FRAC_BITS{1'b0}}};
      metric[2] = {INT_W'(h_diff), {FRAC_BITS{1'b0}}};
      metric[3] = {INT_W'(hist), {FRAC_BITS{1'b0}}};
      for (int c = 0; c < NUM_COLORS; c++) begin
         csum = '0;
         for (int j = 0; j < 3; j++) begin
            ch_a = color_cur_q[c*COLOR_LEN + j*CH_LEN +: CH_LEN];
            ch_b = color_prev_q[c*COLOR_LEN + j*CH_LEN +: CH_LEN];
            csum = csum + CSUM_W'((ch_a > ch_b) ? ch_a - ch_b : ch_b - ch_a);
         end
         metric[4+c] = {INT_W'(csum), {FRAC_BITS{1'b0}}};
      end
   end

   always_comb begin
      wgt  = weights_q[k_q*WEIGHT_LEN +: WEIGHT_LEN];
      prod = PROD_W'(wgt) * PROD_W'(metric[k_q]);
   end

`ifdef OFLOW_SIM_SATURATE_EN
   localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
   logic [SUM_W-1:0]       acc_sum;
   logic [ACC_W-SHIFT-1:0] shifted;
   logic                   ovf_q, ovf_next;

   // Sticky carry-out: a wrapped accumulator must still saturate.
   always_comb begin
      acc_sum  = SUM_W'(acc_q) + SUM_W'(prod);
      ovf_next = ovf_q | (|acc_sum[SUM_W-1:ACC_W]);
      acc_next = acc_sum[ACC_W-1:0];
      shifted  = acc_next[ACC_W-1:SHIFT];
      if (ovf_next || (|shifted[ACC_W-SHIFT-1:SCORE_LEN])) score_next = '1;
      else                                                   score_next = shifted[SCORE_LEN-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset)                 ovf_q <= 1'b0;
      else if (load_feat)        ovf_q <= 1'b0;
      else if (state_q == S_MAC) ovf_q <= ovf_next;
   end
`else
   always_comb begin
      acc_next   = acc_q + ACC_W'(prod);
      score_next = acc_next[SHIFT +: SCORE_LEN];
   end
`endif

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      acc_d     = acc_q;
      score_d   = score_q;
      id_d      = id_q;
      load_feat = 1'b0;
      load_iou  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               load_feat = 1'b1;
               acc_d     = '0;
               state_d   = S_WAIT_IOU;
            end
         end
         S_WAIT_IOU: begin
            if (bus.iou_valid) begin
               load_iou = 1'b1;
               k_d      = '0;
               state_d  = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_next;
            if (k_q == KW'(NUM_TERMS - 1)) begin
               score_d = score_next;
               id_d    = id_prev_q;
               state_d = S_OUT;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         score_q <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         score_q <= score_d;
         id_q    <= id_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         width_cur_q   <= '0;
         width_prev_q  <= '0;
         height_cur_q  <= '0;
         height_prev_q <= '0;
         color_cur_q   <= '0;
         color_prev_q  <= '0;
         d_history_q   <= '0;
         id_prev_q     <= '0;
         weights_q     <= '0;
         iou_pad_q     <= '0;
      end else begin
         if (load_feat) begin
            width_cur_q   <= bus.width_cur;
            width_prev_q  <= bus.width_prev;
            height_cur_q  <= bus.height_cur;
            height_prev_q <= bus.height_prev;
            color_cur_q   <= bus.color_cur;
            color_prev_q  <= bus.color_prev;
            d_history_q   <= bus.d_history_prev;
            id_prev_q     <= bus.id_prev;
            weights_q     <= bus.weights;
         end
         if (load_iou) iou_pad_q <= bus.iou_in[IOU_LEN-1 -: FRAC_BITS];
      end
   end

   assign bus.busy                      = (state_q != S_IDLE);
   assign bus.valid                     = (state_q == S_OUT);
   assign bus.control_for_read_new_line = (state_q == S_MAC) && (k_q == KW'(RA_K));
   assign bus.score                     = score_q;
   assign bus.id                        = id_q;
endmodule

// File: tb/tb_oflow_similarity_metric_param.sv
// Directed bench for the similarity-metric engine: default instance plus a
// four-colour, 16-bit-score, long read-ahead instance; results checked through scoreboards.
module tb_oflow_similarity_metric_param;
   logic clk = 1'b0;
   logic rst0, rst1;
   always #5 clk = ~clk;

   oflow_similarity_metric_param_if if0 ();
   oflow_similarity_metric_param_if #(.NUM_COLORS(4), .SCORE_LEN(16)) if1 ();

   oflow_similarity_metric_param dut0 (.clk(clk), .reset(rst0), .bus(if0.slave));
   oflow_similarity_metric_param #(.NUM_COLORS(4), .SCORE_LEN(16), .READ_AHEAD(10))
      dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));

   typedef struct {logic [31:0] score; logic [7:0] id;} exp_t;
   exp_t q0[$];
   exp_t q1[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int vcnt0 = 0, vcnt1 = 0, ra_cnt0 = 0, ra_cnt1 = 0;
   int val_cyc0 = 0, val_cyc1 = 0, ra_cyc0 = 0, ra_cyc1 = 0;
   int st_cyc = 0;

   logic [7:0]  wc, wp, hc, hp, idp;
   logic [2:0]  dh;
   logic [95:0] cc, cp;
   logic [63:0] wts;
   logic [21:0] iou;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   // Straight weighted sum in q.10, independent of the serial datapath.
   function automatic logic [63:0] model_sum(input int nc);
      logic [63:0] s;
      int d;
      s = 64'(wts[7:0]) * 64'(iou[21:12]);
      s = s + 64'(wts[15:8]) * 64'(absd(int'(wc), int'(wp))) * 1024;
      s = s + 64'(wts[23:16]) * 64'(absd(int'(hc), int'(hp))) * 1024;
      s = s + 64'(wts[31:24]) * (64'(1) << dh) * 1024;
      for (int c = 0; c < nc; c++) begin
         d = 0;
         for (int j = 0; j < 3; j++)
            d += absd(int'(cc[c*24 + j*8 +: 8]), int'(cp[c*24 + j*8 +: 8]));
         s = s + 64'(wts[(4+c)*8 +: 8]) * 64'(d) * 1024;
      end
      return s;
   endfunction

   function automatic logic [31:0] exp_score(input int u);
      logic [63:0] sh, mx;
      int sl;
      sl = (u == 0) ? 32 : 16;
      sh = model_sum((u == 0) ? 2 : 4) >> 4;
      mx = (64'(1) << sl) - 1;
`ifdef OFLOW_SIM_SATURATE_EN
      if (sh > mx) return 32'(mx);
`endif
      return 32'(sh & mx);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (if0.control_for_read_new_line) begin ra_cnt0++; ra_cyc0 = cyc; end
      if (if1.control_for_read_new_line) begin ra_cnt1++; ra_cyc1 = cyc; end
      if (if0.valid) begin
         vcnt0++; val_cyc0 = cyc;
         check("expected0_pending", 64'(q0.size() != 0), 64'(1));
         if (q0.size() != 0) begin
            e = q0.pop_front();
            check("score0", 64'(if0.score), 64'(e.score));
            check("id0", 64'(if0.id), 64'(e.id));
         end
      end
      if (if1.valid) begin
         vcnt1++; val_cyc1 = cyc;
         check("expected1_pending", 64'(q1.size() != 0), 64'(1));
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check("score1", 64'(if1.score), 64'(e.score));
            check("id1", 64'(if1.id), 64'(e.id));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input int u);
      if (u == 0) begin
         if0.width_cur = wc;  if0.width_prev = wp;
         if0.height_cur = hc; if0.height_prev = hp;
         if0.color_cur = cc[47:0]; if0.color_prev = cp[47:0];
         if0.d_history_prev = dh; if0.id_prev = idp;
         if0.weights = wts[47:0]; if0.iou_in = iou;
      end else begin
         if1.width_cur = wc;  if1.width_prev = wp;
         if1.height_cur = hc; if1.height_prev = hp;
         if1.color_cur = cc; if1.color_prev = cp;
         if1.d_history_prev = dh; if1.id_prev = idp;
         if1.weights = wts; if1.iou_in = iou;
      end
   endtask

   task automatic set_start(input int u, input logic v);
      if (u == 0) if0.start = v; else if1.start = v;
   endtask

   task automatic set_iou(input int u, input logic v);
      if (u == 0) if0.iou_valid = v; else if1.iou_valid = v;
   endtask

   task automatic push(input int u, input logic [31:0] s);
      exp_t e;
      e.score = s;
      e.id    = idp;
      if (u == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   // Start at st_cyc, iou_valid d cycles later; waits (bounded) for the result.
   task automatic run(input int u, input int d, input logic early, input logic [31:0] exp);
      int v0, n;
      apply(u);
      push(u, exp);
      v0 = (u == 0) ? vcnt0 : vcnt1;
      st_cyc = cyc;
      set_start(u, 1'b1);
      set_iou(u, early);
      tick();
      set_start(u, 1'b0);
      set_iou(u, 1'b0);
      repeat (d - 1) tick();
      set_iou(u, 1'b1);
      tick();
      set_iou(u, 1'b0);
      n = 0;
      while ((((u == 0) ? vcnt0 : vcnt1) == v0) && n < 40) begin tick(); n++; end
      check("result_count", 64'(((u == 0) ? vcnt0 : vcnt1) - v0), 64'(1));
   endtask

   initial begin
      int idle, v0, r0, n;
      rst0 = 1'b1; rst1 = 1'b1;
      wc = '0; wp = '0; hc = '0; hp = '0; idp = '0; dh = '0;
      cc = '0; cp = '0; wts = '0; iou = '0;
      apply(0); apply(1);
      set_start(0, 1'b0); set_start(1, 1'b0);
      set_iou(0, 1'b0); set_iou(1, 1'b0);
      repeat (3) tick();
      rst0 = 1'b0; rst1 = 1'b0;
      check("rst_busy0", 64'(if0.busy), 0);
      check("rst_valid0", 64'(if0.valid), 0);
      check("rst_ra0", 64'(if0.control_for_read_new_line), 0);
      check("rst_score0", 64'(if0.score), 0);
      check("rst_id0", 64'(if0.id), 0);
      check("rst_busy1", 64'(if1.busy), 0);
      check("rst_score1", 64'(if1.score), 0);
      tick();

      // Basic score: diffs w10 h5 hist4 colour 3+4+5, all weights 1 -> 31.0
      wp = 8'd20; wc = 8'd10; hp = 8'd7; hc = 8'd12; dh = 3'd2;
      cc = '0; cp = '0;
      cc[23:0] = {8'd13, 8'd14, 8'd15}; cp[23:0] = {8'd10, 8'd10, 8'd10};
      cc[47:24] = 24'h556677; cp[47:24] = 24'h556677;
      wts = {8{8'd1}}; iou = '0; idp = 8'hA5;
      r0 = ra_cnt0;
      run(0, 3, 1'b0, 32'd1984);
      check("basic_ra_cycle", 64'(ra_cyc0 - st_cyc), 64'(7));
      check("basic_valid_cycle", 64'(val_cyc0 - st_cyc), 64'(10));
      check("basic_ra_count", 64'(ra_cnt0 - r0), 64'(1));
      check("basic_busy_after", 64'(if0.busy), 0);

      // IoU only: 0.5 * 4 -> 2.0
      iou = 22'd1 << 21; wts = '0; wts[7:0] = 8'd4; idp = 8'h3C;
      run(0, 1, 1'b0, 32'd128);
      check("iou_valid_cycle", 64'(val_cyc0 - st_cyc), 64'(8));

      // iou_valid during the start cycle is not taken; the later one is.
      wp = 8'd3; wc = 8'd200; hp = 8'd90; hc = 8'd9; dh = 3'd7;
      cc[47:0] = 48'h0A_FF_30_12_00_C8; cp[47:0] = 48'h80_01_30_40_FF_00;
      wts = 64'h0000_0304_0A05_0207; iou = 22'h2ABCDE; idp = 8'h71;
      run(0, 4, 1'b1, exp_score(0));
      check("early_iou_valid_cycle", 64'(val_cyc0 - st_cyc), 64'(11));
      check("score_hold", 64'(if0.score), 64'(exp_score(0)));

      // Start and iou_valid held high: one pass every 9 cycles, starts while busy ignored.
      wp = 8'd50; wc = 8'd40; hp = 8'd1; hc = 8'd2; dh = 3'd1;
      wts = 64'h0000_0102_0304_0506; iou = 22'h100000; idp = 8'h42;
      apply(0);
      for (int i = 0; i < 4; i++) push(0, exp_score(0));
      v0 = vcnt0; idle = 0;
      for (int i = 0; i < 30; i++) begin
         set_start(0, 1'b1); set_iou(0, 1'b1);
         if (!if0.busy) idle++;
         tick();
      end
      set_start(0, 1'b0); set_iou(0, 1'b0);
      n = 0;
      while (vcnt0 - v0 < 4 && n < 40) begin tick(); n++; end
      check("hs_idle_cycles", 64'(idle), 64'(4));
      check("hs_results", 64'(vcnt0 - v0), 64'(4));
      repeat (12) tick();
      check("hs_no_extra", 64'(vcnt0 - v0), 64'(4));

      // Reset at k=2 aborts with no result; then a fresh run completes.
      wp = 8'd9; wc = 8'd1; idp = 8'h99;
      apply(0);
      v0 = vcnt0;
      set_start(0, 1'b1); tick(); set_start(0, 1'b0);
      set_iou(0, 1'b1); tick(); set_iou(0, 1'b0);
      tick(); tick();
      rst0 = 1'b1; tick(); rst0 = 1'b0;
      check("rst_mid_busy", 64'(if0.busy), 0);
      check("rst_mid_score", 64'(if0.score), 0);
      check("rst_mid_id", 64'(if0.id), 0);
      repeat (12) tick();
      check("rst_mid_no_valid", 64'(vcnt0 - v0), 0);
      run(0, 2, 1'b0, exp_score(0));

      // Four colours, read-ahead beyond the term count -> pulse at k=0.
      wp = 8'd30; wc = 8'd25; hp = 8'd4; hc = 8'd4; dh = 3'd0;
      cc = {24'h010203, 24'h102030, 24'h0000FF, 24'h808080};
      cp = {24'h030201, 24'h102030, 24'hFF0000, 24'h707890};
      wts = {8'd2, 8'd3, 8'd1, 8'd4, 8'd1, 8'd2, 8'd1, 8'd5};
      iou = 22'h3FFFFF; idp = 8'hC3;
      r0 = ra_cnt1;
      run(1, 1, 1'b0, exp_score(1));
      check("nc4_ra_cycle", 64'(ra_cyc1 - st_cyc), 64'(2));
      check("nc4_valid_cycle", 64'(val_cyc1 - st_cyc), 64'(10));
      check("nc4_ra_count", 64'(ra_cnt1 - r0), 64'(1));

      // Colour diffs 765 each, weights 255: 16-bit score overflows.
      wp = 8'd77; wc = 8'd77; hp = 8'd5; hc = 8'd5; dh = 3'd0;
      cc = {12{8'hFF}}; cp = '0; wts = {8{8'hFF}}; iou = '0; idp = 8'h5A;
`ifdef OFLOW_SIM_SATURATE_EN
      run(1, 2, 1'b0, 32'h0000_FFFF);
`else
      run(1, 2, 1'b0, exp_score(1));
`endif

      repeat (3) tick();
      check("q0_drained", 64'(q0.size()), 0);
      check("q1_drained", 64'(q1.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
